// File: rtl/mem_stage_pkg.sv
// Shared LC-3b types for the memory-access stage: word type, control-word
// bit positions and the access FSM encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  localparam int CW_MEM_READ  = 0;
  localparam int CW_MEM_WRITE = 1;
  localparam int CW_BYTE      = 2;
  localparam int CW_INDIRECT  = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_IND_RD,
    S_DATA_ACC,
    S_COMPLETE
  } mem_state_t;

  function automatic lc3b_word sext8(input logic [7:0] b);
    return {{8{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_byte_align.sv
// Byte-lane steering for data-memory accesses: lane enables, replicated store
// data and aligned, sign-extended load data.
module mem_byte_align
  import lc3b_types::*;
(
  input  logic     addr_lsb,
  input  logic     byte_op,
  input  lc3b_word sr_data,
  input  lc3b_word rdata,
  output logic [1:0] byte_enable,
  output lc3b_word wdata,
  output lc3b_word rdata_aligned
);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    byte_enable   = 2'b11;
    wdata         = sr_data;
    rdata_aligned = rdata;
    if (byte_op) begin
      byte_enable   = addr_lsb ? 2'b10 : 2'b01;
      // The selected lane of the memory is written, so the byte goes on both lanes.
      wdata         = {sr_data[7:0], sr_data[7:0]};
      rdata_aligned = addr_lsb ? sext8(rdata[15:8]) : sext8(rdata[7:0]);
    end
  end

endmodule

// File: rtl/mem_stage.sv
// LC-3b MEM stage: runs direct and indirect loads/stores over the data-memory
// handshake and stalls the upstream pipeline while an access is in flight.
module mem_stage
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       valid_in,
  input  lc3b_word   ir_in,
  input  lc3b_word   pc_in,
  input  lc3b_word   alu_in,
  input  lc3b_word   cw_in,
  input  lc3b_word   sr_data_in,
  output lc3b_word   mem_address,
  output logic       mem_read,
  output logic       mem_write,
  output logic [1:0] mem_byte_enable,
  output lc3b_word   mem_wdata,
  input  lc3b_word   mem_rdata,
  input  logic       mem_resp,
  output logic       stall,
  output logic       done,
  output lc3b_word   mem_data_out
);

  mem_state_t state_q, state_d;
  lc3b_word   ind_addr_q, ind_addr_d;
  lc3b_word   mem_data_out_q, mem_data_out_d;

  logic     is_rd, is_wr, is_ind, is_byte, mem_op;
  lc3b_word addr_raw;
  lc3b_word rdata_aligned;

  // ir_in and pc_in travel alongside in the pipeline but are not used here.
  logic unused_ok;
  assign unused_ok = ^{ir_in, pc_in, cw_in[15:4]};

  assign is_rd   = cw_in[CW_MEM_READ];
  assign is_wr   = cw_in[CW_MEM_WRITE];
  assign is_ind  = cw_in[CW_INDIRECT];
  assign is_byte = cw_in[CW_BYTE] & ~is_ind;
  assign mem_op  = valid_in & (is_rd | is_wr);

  // The pointer fetch always uses alu_in; the data phase uses the fetched pointer when indirect.
  assign addr_raw    = (state_q == S_DATA_ACC && is_ind) ? ind_addr_q : alu_in;
  assign mem_address = {addr_raw[15:1], 1'b0};

  mem_byte_align u_align (
    .addr_lsb      (addr_raw[0]),
    .byte_op       (is_byte && state_q != S_IND_RD),
    .sr_data       (sr_data_in),
    .rdata         (mem_rdata),
    .byte_enable   (mem_byte_enable),
    .wdata         (mem_wdata),
    .rdata_aligned (rdata_aligned)
  );

  always_comb begin
    state_d        = state_q;
    ind_addr_d     = ind_addr_q;
    mem_data_out_d = mem_data_out_q;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    stall          = 1'b0;
    done           = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          stall   = 1'b1;
          state_d = is_ind ? S_IND_RD : S_DATA_ACC;
        end else if (valid_in) begin
          done = 1'b1;
        end
      end
      S_IND_RD: begin
        stall    = 1'b1;
        mem_read = 1'b1;
        if (mem_resp) begin
          ind_addr_d = mem_rdata;
          state_d    = S_DATA_ACC;
        end
      end
      S_DATA_ACC: begin
        stall     = 1'b1;
        mem_read  = is_rd;
        mem_write = is_wr & ~is_rd;
        if (mem_resp) begin
          if (is_rd) mem_data_out_d = rdata_aligned;
          state_d = S_COMPLETE;
        end
      end
      S_COMPLETE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      ind_addr_q     <= '0;
      mem_data_out_q <= '0;
    end else begin
      state_q        <= state_d;
      ind_addr_q     <= ind_addr_d;
      mem_data_out_q <= mem_data_out_d;
    end
  end

  assign mem_data_out = mem_data_out_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a small handshake responder with programmable
// wait states drives each access and the observed bus activity is checked.
module tb_mem_stage;
  import lc3b_types::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  lc3b_word   ir_in, pc_in, alu_in, cw_in, sr_data_in;
  lc3b_word   mem_address, mem_wdata, mem_rdata, mem_data_out;
  logic       mem_read, mem_write, mem_resp, stall, done;
  logic [1:0] mem_byte_enable;

  mem_stage dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .ir_in           (ir_in),
    .pc_in           (pc_in),
    .alu_in          (alu_in),
    .cw_in           (cw_in),
    .sr_data_in      (sr_data_in),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .stall           (stall),
    .done            (done),
    .mem_data_out    (mem_data_out)
  );

  always #5 clk = ~clk;

  localparam lc3b_word CW_RD  = 16'h0001;
  localparam lc3b_word CW_WR  = 16'h0002;
  localparam lc3b_word CW_BY  = 16'h0004;
  localparam lc3b_word CW_IND = 16'h0008;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Per-transaction observations.
  int       stall_cnt, done_cnt, done_cyc, n_req;
  lc3b_word req_addr [2];
  lc3b_word req_be   [2];
  lc3b_word req_wr   [2];
  lc3b_word req_wdata[2];
  logic     req_at_done;

  // Called just after a rising edge; returns just after the edge that leaves COMPLETE.
  task automatic run_op(input lc3b_word ir, input lc3b_word alu, input lc3b_word cw,
                        input lc3b_word sr, input lc3b_word rd0, input lc3b_word rd1,
                        input int waits);
    int wcnt = 0;
    bit fin  = 0;
    stall_cnt = 0; done_cnt = 0; done_cyc = -1; n_req = 0; req_at_done = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_be[i] = '0; req_wr[i] = '0; req_wdata[i] = '0;
    end
    valid_in = 1'b1; ir_in = ir; pc_in = 16'h0100; alu_in = alu; cw_in = cw;
    sr_data_in = sr; mem_resp = 1'b0;
    for (int c = 0; c < 30 && !fin; c++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin
        done_cnt++; done_cyc = c; fin = 1;
        req_at_done = mem_read | mem_write;
      end else if ((mem_read || mem_write) && n_req < 2) begin
        if (wcnt == waits) begin
          req_addr[n_req]  = mem_address;
          req_be[n_req]    = {14'h0, mem_byte_enable};
          req_wr[n_req]    = {15'h0, mem_write};
          req_wdata[n_req] = mem_wdata;
          mem_rdata        = (n_req == 0) ? rd0 : rd1;
          mem_resp         = 1'b1;
          n_req++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
      @(posedge clk);
      #1 mem_resp = 1'b0;
    end
    valid_in = 1'b0;
    if (!fin) check("op_timeout_no_done", 16'h0, 16'h1);
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; ir_in = '0; pc_in = '0; alu_in = '0;
    cw_in = '0; sr_data_in = '0; mem_rdata = '0; mem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_data_out", mem_data_out, 16'h0000);
    check("rst_done", {15'h0, done}, 16'h0);
    check("rst_stall", {15'h0, stall}, 16'h0);
    check("rst_req", {14'h0, mem_read, mem_write}, 16'h0);
    @(posedge clk); #1;

    // LDR with two wait states.
    run_op(16'h6000, 16'h3004, CW_RD, 16'h0, 16'hBEEF, 16'h0, 2);
    check("ldr_addr", req_addr[0], 16'h3004);
    check("ldr_be", req_be[0], 16'h0003);
    check("ldr_is_read", req_wr[0], 16'h0000);
    check("ldr_stall_cycles", 16'(stall_cnt), 16'd4);
    check("ldr_done_cycle", 16'(done_cyc), 16'd4);
    check("ldr_data", mem_data_out, 16'hBEEF);
    check("ldr_req_low_at_done", {15'h0, req_at_done}, 16'h0);

    // LDB high byte, then low byte, zero wait.
    run_op(16'h2000, 16'h3005, CW_RD | CW_BY, 16'h0, 16'h8A12, 16'h0, 0);
    check("ldb_hi_addr", req_addr[0], 16'h3004);
    check("ldb_hi_be", req_be[0], 16'h0002);
    check("ldb_hi_data", mem_data_out, 16'hFF8A);
    check("ldb_hi_done_cycle", 16'(done_cyc), 16'd2);
    run_op(16'h2000, 16'h3004, CW_RD | CW_BY, 16'h0, 16'h8A12, 16'h0, 0);
    check("ldb_lo_be", req_be[0], 16'h0001);
    check("ldb_lo_data", mem_data_out, 16'h0012);

    // STB to an odd address.
    run_op(16'h3000, 16'h2001, CW_WR | CW_BY, 16'h1234, 16'h0, 16'h0, 1);
    check("stb_is_write", req_wr[0], 16'h0001);
    check("stb_addr", req_addr[0], 16'h2000);
    check("stb_be", req_be[0], 16'h0002);
    check("stb_wdata", req_wdata[0], 16'h3434);
    check("stb_data_unchanged", mem_data_out, 16'h0012);

    // STR word store.
    run_op(16'h7000, 16'h2002, CW_WR, 16'hCAFE, 16'h0, 16'h0, 1);
    check("str_be", req_be[0], 16'h0003);
    check("str_wdata", req_wdata[0], 16'hCAFE);
    check("str_done_cycle", 16'(done_cyc), 16'd3);
    check("str_data_unchanged", mem_data_out, 16'h0012);

    // LDI with CW_BYTE also set: must still be a word access.
    run_op(16'hA000, 16'h4000, CW_RD | CW_IND | CW_BY, 16'h0, 16'h5002, 16'h00AA, 0);
    check("ldi_nreq", 16'(n_req), 16'd2);
    check("ldi_ptr_addr", req_addr[0], 16'h4000);
    check("ldi_ptr_be", req_be[0], 16'h0003);
    check("ldi_data_addr", req_addr[1], 16'h5002);
    check("ldi_data_be", req_be[1], 16'h0003);
    check("ldi_data", mem_data_out, 16'h00AA);
    check("ldi_done_cycle", 16'(done_cyc), 16'd3);
    check("ldi_stall_cycles", 16'(stall_cnt), 16'd3);

    // ADD then a bubble.
    valid_in = 1'b1; ir_in = 16'h1000; cw_in = 16'h0000; alu_in = 16'h3004;
    @(negedge clk);
    check("add_done", {15'h0, done}, 16'h1);
    check("add_stall", {15'h0, stall}, 16'h0);
    check("add_no_req", {14'h0, mem_read, mem_write}, 16'h0);
    @(posedge clk); #1 valid_in = 1'b0;
    @(negedge clk);
    check("bubble_done", {15'h0, done}, 16'h0);
    check("bubble_stall", {15'h0, stall}, 16'h0);
    check("bubble_no_req", {14'h0, mem_read, mem_write}, 16'h0);
    @(posedge clk); #1;

    // Reset in the middle of a read.
    valid_in = 1'b1; ir_in = 16'h6000; cw_in = CW_RD; alu_in = 16'h3004;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_read_active", {15'h0, mem_read}, 16'h1);
    #2 reset = 1'b1; valid_in = 1'b0;
    #1;
    check("mid_rst_read_drop", {15'h0, mem_read}, 16'h0);
    check("mid_rst_data_out", mem_data_out, 16'h0000);
    @(posedge clk); #1 reset = 1'b0;
    mem_rdata = 16'h1111; mem_resp = 1'b1;
    @(negedge clk);
    check("late_resp_done", {15'h0, done}, 16'h0);
    check("late_resp_stall", {15'h0, stall}, 16'h0);
    @(posedge clk); #1 mem_resp = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("post_rst_done", {15'h0, done}, 16'h0);
      check("post_rst_req", {14'h0, mem_read, mem_write}, 16'h0);
    end
    check("post_rst_data_out", mem_data_out, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
